// File: rtl/lbm_pkg.sv
// Shared D2Q9 lattice constants and types for the LBM engine stages.
package lbm_pkg;

    localparam int Q = 9;

    typedef enum logic [3:0] {
        DIR_REST = 4'd0,
        DIR_E    = 4'd1,
        DIR_N    = 4'd2,
        DIR_W    = 4'd3,
        DIR_S    = 4'd4,
        DIR_NE   = 4'd5,
        DIR_NW   = 4'd6,
        DIR_SW   = 4'd7,
        DIR_SE   = 4'd8
    } dir_e;

    // Lattice velocities, indexed by direction; +y is north.
    localparam logic signed [1:0] CX [Q] = '{2'sb00, 2'sb01, 2'sb00, 2'sb11, 2'sb00,
                                             2'sb01, 2'sb11, 2'sb11, 2'sb01};
    localparam logic signed [1:0] CY [Q] = '{2'sb00, 2'sb00, 2'sb01, 2'sb00, 2'sb11,
                                             2'sb01, 2'sb01, 2'sb11, 2'sb11};
    localparam int OPP [Q] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stream_state_e;

endpackage

// File: rtl/lbm_stream_addr_gen.sv
// Scan counters and per-lane pull-source addresses with bounce-back flags.
module lbm_stream_addr_gen
    import lbm_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 144,
    parameter int X_W    = $clog2(WIDTH),
    parameter int Y_W    = $clog2(HEIGHT),
    parameter int ADDR_W = X_W + Y_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue,
    output logic [Q*ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]     addr_b,
    output logic [Q-1:0]          bounce,
    output logic                  cell_zero
);

    logic [X_W-1:0]      x_cnt;
    logic [Y_W-1:0]      y_cnt;
    logic [X_W-1:0]      src_x [Q];
    logic [Y_W-1:0]      src_y [Q];
    logic [Q-1:0]        bounce_nxt;
    logic [Q*ADDR_W-1:0] addr_a_nxt;

    assign cell_zero = (x_cnt == '0) && (y_cnt == '0);

    // x wraps for free in X_W bits; y leaving the grid selects bounce-back.
    always_comb begin
        bounce_nxt = '0;
        addr_a_nxt = '0;
        for (int i = 0; i < Q; i++) begin
            src_x[i] = x_cnt;
            src_y[i] = y_cnt;
            if (CX[i] == 2'sb01)
                src_x[i] = x_cnt - X_W'(1);
            else if (CX[i] == 2'sb11)
                src_x[i] = x_cnt + X_W'(1);
            if (CY[i] == 2'sb01) begin
                src_y[i]      = y_cnt - Y_W'(1);
                bounce_nxt[i] = (y_cnt == '0);
            end else if (CY[i] == 2'sb11) begin
                src_y[i]      = y_cnt + Y_W'(1);
                bounce_nxt[i] = (y_cnt == Y_W'(HEIGHT - 1));
            end
            addr_a_nxt[i*ADDR_W +: ADDR_W] = bounce_nxt[i] ? {y_cnt, x_cnt}
                                                           : {src_y[i], src_x[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt  <= '0;
            y_cnt  <= '0;
            addr_a <= '0;
            addr_b <= '0;
            bounce <= '0;
        end else if (issue) begin
            addr_a <= addr_a_nxt;
            addr_b <= {y_cnt, x_cnt};
            bounce <= bounce_nxt;
            x_cnt  <= x_cnt + X_W'(1);
            if (x_cnt == X_W'(WIDTH - 1))
                y_cnt <= (y_cnt == Y_W'(HEIGHT - 1)) ? '0 : y_cnt + Y_W'(1);
        end
    end

endmodule

// File: rtl/lbm_stream.sv
// D2Q9 streaming stage: pull-based stream with periodic x and bounce-back walls.
module lbm_stream
    import lbm_pkg::*;
#(
    parameter  int WIDTH  = 256,
    parameter  int HEIGHT = 144,
    parameter  int DATA_W = 16,
    localparam int X_W    = $clog2(WIDTH),
    localparam int Y_W    = $clog2(HEIGHT),
    localparam int ADDR_W = X_W + Y_W
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    output logic                busy_out,
    output logic                done_out,
    output logic [Q*ADDR_W-1:0] rd_addr_a_out,
    output logic [ADDR_W-1:0]   rd_addr_b_out,
    input  logic [Q*DATA_W-1:0] rd_data_a_in,
    input  logic [Q*DATA_W-1:0] rd_data_b_in,
    output logic                wr_en_out,
    output logic [ADDR_W-1:0]   wr_addr_out,
    output logic [Q*DATA_W-1:0] wr_data_out,
    output logic [1:0]          state_out
);

    stream_state_e       state, state_nxt;
    logic [1:0]          drain_cnt;
    logic                issue;
    logic                cell_zero;
    logic [Q-1:0]        bounce0, bounce1, bounce2;
    logic                vld0, vld1, vld2;
    logic [ADDR_W-1:0]   dest1, dest2;
    logic [Q*DATA_W-1:0] lane_data;

    lbm_stream_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .issue     (issue),
        .addr_a    (rd_addr_a_out),
        .addr_b    (rd_addr_b_out),
        .bounce    (bounce0),
        .cell_zero (cell_zero)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Cell 0 is issued on the accepting edge, so the counter returning to
    // zero while in RUN means every cell has been issued.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_in) begin
                    issue     = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cell_zero)
                    state_nxt = ST_DRAIN;
                else
                    issue = 1'b1;
            end
            ST_DRAIN: begin
                if (drain_cnt == 2'd2)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy_out  = (state == ST_RUN) || (state == ST_DRAIN);
    assign done_out  = (state == ST_DONE);
    assign state_out = state;

    // Flags and destination travel with the 2-cycle BRAM read latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld0    <= 1'b0;
            vld1    <= 1'b0;
            vld2    <= 1'b0;
            bounce1 <= '0;
            bounce2 <= '0;
            dest1   <= '0;
            dest2   <= '0;
        end else begin
            vld0    <= issue;
            vld1    <= vld0;
            vld2    <= vld1;
            bounce1 <= bounce0;
            bounce2 <= bounce1;
            dest1   <= rd_addr_b_out;
            dest2   <= dest1;
        end
    end

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < Q; i++) begin
            lane_data[i*DATA_W +: DATA_W] = bounce2[i] ? rd_data_b_in[OPP[i]*DATA_W +: DATA_W]
                                                       : rd_data_a_in[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_en_out   <= 1'b0;
            wr_addr_out <= '0;
            wr_data_out <= '0;
        end else begin
            wr_en_out <= vld2;
            if (vld2) begin
                wr_addr_out <= dest2;
                wr_data_out <= lane_data;
            end
        end
    end

endmodule

// File: doc/lbm_stream.md
# lbm_stream

Streaming stage of the D2Q9 Lattice Boltzmann engine. It runs when the top-level LBM controller enters STREAMING and pulls post-collision distributions from nine direction banks into a destination buffer. The stream is pull-based: the destination cell (x,y), direction i, receives the value from source cell (x−cx_i, y−cy_i). The x edges wrap periodically. The top and bottom rows are no-slip walls handled by bounce-back. Throughput is one lattice cell per cycle.

## Interface

- Parameters:
  - WIDTH, default 256: lattice columns. Must be a power of two.
  - HEIGHT, default 144: lattice rows.
  - DATA_W, default 16: bits per distribution value.
  - X_W = $clog2(WIDTH), Y_W = $clog2(HEIGHT), ADDR_W = X_W+Y_W: derived widths, not overridden.
- Ports:
  - clk_in, input, 1: system clock.
  - rst_n_in, input, 1: asynchronous, active-low reset.
  - start_in, input, 1: single-cycle request to begin a pass.
  - busy_out, output, 1: high from the cycle after an accepted start until done_out.
  - done_out, output, 1: one-cycle pulse after the last write.
  - rd_addr_a_out, output, 9×ADDR_W: per-bank port-A read address (pull source).
  - rd_addr_b_out, output, ADDR_W: shared port-B read address, equal to the destination cell.
  - rd_data_a_in, input, 9×DATA_W: port-A data, 2-cycle latency.
  - rd_data_b_in, input, 9×DATA_W: port-B data, 2-cycle latency.
  - wr_en_out, output, 1: destination buffer write enable.
  - wr_addr_out, output, ADDR_W: destination write address.
  - wr_data_out, output, 9×DATA_W: all nine streamed values for the cell.

## Operation

- Address map: addr = {y, x}. Row y=0 is the bottom wall row; y=HEIGHT−1 is the top wall row.
- Directions: 0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE. N means +y.
- Opposites: OPP = {0,3,4,1,2,7,8,5,6}.
- FSM states and transitions:
  - IDLE: start_in moves the FSM to RUN.
  - RUN: scans x fastest, then y, from 0 to WIDTH·HEIGHT−1. Issues one address set per cycle. Enters DRAIN after issuing the last cell.
  - DRAIN: 3 cycles, until the last write has been issued.
  - DONE: one cycle, done_out=1, then IDLE.
- Source x for lane i: (x − cx_i) mod WIDTH. This is natural X_W-bit wrap, with no compare.
- Source y for lane i: y − cy_i. If the result is < 0 or ≥ HEIGHT, the lane is in bounce-back:
  - rd_addr_a_out[i] is driven to the destination address. The value is don't-care but deterministic.
  - The lane output is rd_data_b_in[OPP[i]].
  - Otherwise the lane output is rd_data_a_in[i].
- Per-lane bounce-back flags are pipelined alongside the read latency.
- start_in is ignored while busy_out=1 or in DONE.
- Reset values: state IDLE, counters 0, busy_out 0, done_out 0, wr_en_out 0, all addresses and wr_data_out 0.
- Reset mid-pass aborts the pass immediately. There is no resumption; the destination buffer contents are undefined.

## Timing

- Cycle t, RUN, scanning cell c: the addresses for c appear on rd_addr_*_out (registered).
- Cycle t+2: BRAM data for c is valid.
- Cycle t+3: wr_en_out=1, wr_addr_out=c, wr_data_out = muxed lanes (registered).
- First write occurs 4 cycles after the start_in cycle.
- wr_en_out is continuous for WIDTH·HEIGHT cycles, with no bubbles.
- done_out asserts the cycle after the final write. busy_out falls in that same cycle.
- Total start-to-done: WIDTH·HEIGHT + 4 cycles.

## Structure

- lbm_pkg holds:
  - Q=9.
  - Direction enum.
  - CX, CY as signed 2-bit constant arrays.
  - OPP array.
  - Shared by the collision stage and the top-level FSM.
- Sub-module lbm_stream_addr_gen contains the x/y scan counters, per-lane source address generation, and bounce-back flags. It is purely address-side.
- lbm_stream itself owns the FSM, the 3-stage flag/valid pipeline, the lane mux and the output registers.

## Test plan

Use a small grid (WIDTH=8, HEIGHT=4, DATA_W=16) with behavioural 2-cycle BRAM models.

- Impulse: source bank 1 holds 0x0001 only at (3,2), all other entries 0 → destination bank 1 is nonzero only at (4,2). Checks all 9 lanes.
- Periodic wrap: bank 3 (W) holds 0x00AA at (0,1) → it appears at (7,1). Bank 5 (NE) holds 0x0055 at (7,1) → it appears at (0,2).
- Bounce-back: bank 4 (S) holds 0x1234 at (5,0) → destination bank 2 (N) at (5,0) = 0x1234. Top-row mirror: bank 5 at (2,3) = 0x00F0 → destination bank 7 at (2,3) = 0x00F0.
- Timing: pulse start_in at cycle 0 → first wr_en_out at cycle 4, exactly 32 contiguous writes with addresses 0..31 in order, done_out at cycle 36, busy_out low at cycle 36.
- Start while busy: a second start_in at cycle 10 is ignored, giving exactly one done_out. A start_in in the cycle after done_out launches a new pass.
- Reset mid-pass: deassert rst_n_in at cycle 15 → wr_en_out, busy_out and done_out are 0 asynchronously. After release, a new start_in gives a full 32-write pass.
